// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage.
//   FETCH_ADDR_W   : default PC / instruction memory address width
//   FETCH_INSTR_W  : default instruction width
//   FETCH_RESET_PC : default PC loaded on reset
//   fetch_entry_t  : one fetch buffer entry, {pc, instr}
//   sat_inc16      : 16-bit saturating increment used by the stats counters
// The entry layout is built from the package widths, so the top-level
// ADDR_W / INSTR_W parameters must stay equal to these defaults.
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int FETCH_ADDR_W   = 8;
  localparam int FETCH_INSTR_W  = 8;
  localparam int FETCH_RESET_PC = 0;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage : fetch_pkg

// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
// DEPTH-entry synchronous FIFO of fetch_entry_t sitting between the fetch
// PC and the decode stage. Flush has priority over push and pop; a flush
// only clears the pointers and count, stored entries are never rewritten
// except by a new push.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_push        : write i_push_entry at the tail (ignored when full
//                   unless a pop happens in the same cycle)
//   i_push_entry  : entry to enqueue
//   i_pop         : remove the head (ignored when empty)
//   i_flush       : discard all entries, overrides push and pop
//   o_head        : current head entry (valid only when !o_empty)
//   o_count       : number of stored entries
//   o_full        : count == DEPTH
//   o_empty       : count == 0
// ---------------------------------------------------------------------------
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  fetch_entry_t     i_push_entry,
  input  logic             i_pop,
  input  logic             i_flush,
  output fetch_entry_t     o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == CNT_W'(0));

  // When full, a push is still accepted if the head leaves this cycle: the
  // freed slot is exactly the one the write pointer points at.
  assign w_do_pop  = i_pop  & ~i_flush & ~w_empty;
  assign w_do_push = i_push & ~i_flush & (~w_full | w_do_pop);

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_entry;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : fetch_buffer

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
// Fetch stage: owns the PC, addresses the instruction memory, and queues
// {pc, instruction} pairs in a small buffer that decode drains through a
// valid/ready handshake. A redirect flushes the buffer and reloads the PC.
// Optional feature macro: INSTRUCTION_FETCH_STATS_EN adds fetch_count and
// flush_count (16-bit saturating) outputs.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   imem_addr        : instruction memory address (the PC register)
//   imem_data        : instruction memory data for imem_addr, same cycle
//   if_valid         : buffer head holds an instruction
//   if_instr, if_pc  : head instruction and the address it came from
//   id_ready         : decode accepts the head this cycle
//   redirect_valid   : jump taken, flush and refetch from redirect_target
//   redirect_target  : new PC
//   fetch_count      : (stats) enqueues since reset
//   flush_count      : (stats) redirect cycles since reset
// ---------------------------------------------------------------------------
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = FETCH_ADDR_W,
  parameter int INSTR_W  = FETCH_INSTR_W,
  parameter int RESET_PC = FETCH_RESET_PC,
  parameter int DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               id_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target
`ifdef INSTRUCTION_FETCH_STATS_EN
  ,
  output logic [15:0]        fetch_count,
  output logic [15:0]        flush_count
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_pc;

  fetch_entry_t     w_push_entry;
  fetch_entry_t     w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_dequeue;
  logic             w_enqueue;

  // Head valid is taken from the registered occupancy, so neither id_ready
  // nor redirect_valid reaches if_valid combinationally.
  assign w_dequeue = (w_count != CNT_W'(0)) & id_ready;

  // A redirect blocks the enqueue; the buffer also discards any same-cycle
  // handshake because flush overrides pop.
  assign w_enqueue = ~redirect_valid & (~w_full | w_dequeue);

  assign w_push_entry = '{pc: r_pc, instr: imem_data};

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_fetch_buffer (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_enqueue),
    .i_push_entry (w_push_entry),
    .i_pop        (w_dequeue),
    .i_flush      (redirect_valid),
    .o_head       (w_head),
    .o_count      (w_count),
    .o_full       (w_full),
    .o_empty      (w_empty)
  );

  assign imem_addr = r_pc;
  assign if_valid  = ~w_empty;
  assign if_instr  = w_head.instr;
  assign if_pc     = w_head.pc;

  // Program counter: redirect wins, otherwise advance on every enqueue
  // (wrapping modulo 2^ADDR_W) and hold while the buffer is blocked.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= ADDR_W'(RESET_PC);
    end else if (redirect_valid) begin
      r_pc <= redirect_target;
    end else if (w_enqueue) begin
      r_pc <= r_pc + ADDR_W'(1);
    end else begin
      r_pc <= r_pc;
    end
  end

`ifdef INSTRUCTION_FETCH_STATS_EN
  logic [15:0] r_fetch_count;
  logic [15:0] r_flush_count;

  // Saturating event counters for enqueues and redirect cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count <= 16'd0;
      r_flush_count <= 16'd0;
    end else begin
      if (w_enqueue) begin
        r_fetch_count <= sat_inc16(r_fetch_count);
      end else begin
        r_fetch_count <= r_fetch_count;
      end
      if (redirect_valid) begin
        r_flush_count <= sat_inc16(r_flush_count);
      end else begin
        r_flush_count <= r_flush_count;
      end
    end
  end

  assign fetch_count = r_fetch_count;
  assign flush_count = r_flush_count;
`endif

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
// Directed bench for instruction_fetch. The instruction memory is modelled
// as word(addr) = addr*7 + 3 (8-bit), so every address carries a distinct
// instruction. Inputs change 1 ns after a rising edge; outputs are checked
// at that same point, i.e. they reflect the state loaded on that edge.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic       if_valid;
  logic [7:0] if_instr;
  logic [7:0] if_pc;
  logic       id_ready;
  logic       redirect_valid;
  logic [7:0] redirect_target;
`ifdef INSTRUCTION_FETCH_STATS_EN
  logic [15:0] fetch_count;
  logic [15:0] flush_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] word(input logic [7:0] a);
    return a * 8'd7 + 8'd3;
  endfunction

  assign imem_data = word(imem_addr);

  instruction_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .id_ready        (id_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target)
`ifdef INSTRUCTION_FETCH_STATS_EN
    ,
    .fetch_count     (fetch_count),
    .flush_count     (flush_count)
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_pc;

    rst             = 1'b1;
    id_ready        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 8'd0;

    // Reset state
    tick();
    tick();
    check("reset_valid", {15'd0, if_valid}, 16'd0);
    check("reset_pc",    {8'd0, if_pc},     16'd0);
    check("reset_instr", {8'd0, if_instr},  16'd0);
    check("reset_addr",  {8'd0, imem_addr}, 16'd0);

    // Streaming with id_ready high: one instruction per cycle, no bubbles
    rst      = 1'b0;
    id_ready = 1'b1;
    tick();
    check("stream_first_valid", {15'd0, if_valid}, 16'd1);
    check("stream_first_pc",    {8'd0, if_pc},     16'd0);
    check("stream_first_instr", {8'd0, if_instr},  {8'd0, word(8'd0)});
    check("stream_first_addr",  {8'd0, imem_addr}, 16'd1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("stream_valid", {15'd0, if_valid}, 16'd1);
      check("stream_pc",    {8'd0, if_pc},     16'(k));
      check("stream_instr", {8'd0, if_instr},  {8'd0, word(8'(k))});
    end

    // Backpressure: buffer fills with pc 0,1 and the PC holds at 2
    rst      = 1'b1;
    id_ready = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
    end
    check("stall_valid", {15'd0, if_valid}, 16'd1);
    check("stall_pc",    {8'd0, if_pc},     16'd0);
    check("stall_addr",  {8'd0, imem_addr}, 16'd2);
    id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_pc",    {8'd0, if_pc},    16'(k));
      check("drain_instr", {8'd0, if_instr}, {8'd0, word(8'(k))});
      tick();
    end

    // Jump at pc 4 to 7 while the buffer holds 4,5
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
    end
    check("jump_head4", {8'd0, if_pc}, 16'd4);
    id_ready = 1'b0;
    tick();
    check("jump_hold_head", {8'd0, if_pc},     16'd4);
    check("jump_hold_addr", {8'd0, imem_addr}, 16'd6);
    redirect_valid  = 1'b1;
    redirect_target = 8'd7;
    tick();
    redirect_valid = 1'b0;
    check("jump_flush_valid", {15'd0, if_valid}, 16'd0);
    check("jump_flush_addr",  {8'd0, imem_addr}, 16'd7);
    id_ready = 1'b1;
    tick();
    check("jump_target_valid", {15'd0, if_valid}, 16'd1);
    check("jump_target_pc",    {8'd0, if_pc},     16'd7);
    check("jump_target_instr", {8'd0, if_instr},  {8'd0, word(8'd7)});
    tick();
    check("jump_next_pc", {8'd0, if_pc}, 16'd8);

    // Redirect during a live handshake: head is discarded, target in 2 cycles
    check("void_pre_valid", {15'd0, if_valid}, 16'd1);
    redirect_valid  = 1'b1;
    redirect_target = 8'd20;
    tick();
    redirect_valid = 1'b0;
    check("void_flush_valid", {15'd0, if_valid}, 16'd0);
    check("void_flush_addr",  {8'd0, imem_addr}, 16'd20);
    tick();
    check("void_target_valid", {15'd0, if_valid}, 16'd1);
    check("void_target_pc",    {8'd0, if_pc},     16'd20);
    check("void_target_instr", {8'd0, if_instr},  {8'd0, word(8'd20)});

    // PC wrap 254,255,0,1
    redirect_valid  = 1'b1;
    redirect_target = 8'd254;
    tick();
    redirect_valid = 1'b0;
    check("wrap_flush_valid", {15'd0, if_valid}, 16'd0);
    check("wrap_addr",        {8'd0, imem_addr}, 16'd254);
    exp_pc = 8'd254;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("wrap_pc",    {8'd0, if_pc},    {8'd0, exp_pc});
      check("wrap_instr", {8'd0, if_instr}, {8'd0, word(exp_pc)});
      exp_pc = exp_pc + 8'd1;
    end

    // Reset mid-stream flushes to RESET_PC on the same edge
    rst = 1'b1;
    tick();
    check("midrst_valid", {15'd0, if_valid}, 16'd0);
    check("midrst_addr",  {8'd0, imem_addr}, 16'd0);
    rst = 1'b0;
    tick();
    check("midrst_restart_pc", {8'd0, if_pc}, 16'd0);

`ifdef INSTRUCTION_FETCH_STATS_EN
    // Stats counters
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    id_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
    end
    check("stats_fetch_run", fetch_count, 16'd10);
    check("stats_flush_run", flush_count, 16'd0);
    redirect_valid  = 1'b1;
    redirect_target = 8'd3;
    tick();
    redirect_valid = 1'b0;
    check("stats_fetch_redir", fetch_count, 16'd10);
    check("stats_flush_redir", flush_count, 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("stats_fetch_rst", fetch_count, 16'd0);
    check("stats_flush_rst", flush_count, 16'd0);
    check("stats_addr_rst",  {8'd0, imem_addr}, 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_instruction_fetch
